// File: rtl/stack_mips_pkg.sv
// Encodings shared by the stack-MIPS control unit and its users:
// opcodes, ALU operations and the 4-bit FSM state encoding.
package stack_mips_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_POPA  = 4'd2,
    S_POPB  = 4'd3,
    S_EXE   = 4'd4,
    S_PUSHR = 4'd5,
    S_MRD   = 4'd6,
    S_PUSHM = 4'd7,
    S_MWR   = 4'd8,
    S_JMP   = 4'd9,
    S_JZ    = 4'd10
  } state_e;

  // ALU opcodes mirror the low opcode bits of the ALU instructions.
  function automatic logic [1:0] alu_of(input logic [2:0] op);
    unique case (op[1:0])
      2'b00:   alu_of = ALU_ADD;
      2'b01:   alu_of = ALU_SUB;
      2'b10:   alu_of = ALU_AND;
      default: alu_of = ALU_NOT;
    endcase
  endfunction

endpackage

// File: rtl/stack_mips_ctrl.sv
// Multi-cycle Moore control FSM for the 8-bit stack MIPS datapath.
// In: clk, rst (sync, high), opc. Out: datapath strobes, ALUop, ifetch.
module stack_mips_ctrl
  import stack_mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opc,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       pcsrc,
  output logic       PorI,
  output logic       memread,
  output logic       memwrite,
  output logic       IRwrite,
  output logic       MtoS,
  output logic       ldA,
  output logic       ldB,
  output logic       srcA,
  output logic       srcB,
  output logic       push,
  output logic       pop,
  output logic       tos,
  output logic [1:0] ALUop,
  output logic       ifetch
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        unique case (1'b1)
          (opc == OP_PUSH): state_d = S_MRD;
          (opc == OP_JMP):  state_d = S_JMP;
          (opc == OP_JZ):   state_d = S_JZ;
          default:          state_d = S_POPA;
        endcase
      end
      S_POPA: begin
        unique case (1'b1)
          (opc == OP_NOT): state_d = S_EXE;
          (opc == OP_POP): state_d = S_MWR;
          default:         state_d = S_POPB;
        endcase
      end
      S_POPB:  state_d = S_EXE;
      S_EXE:   state_d = S_PUSHR;
      S_MRD:   state_d = S_PUSHM;
      default: state_d = S_IF;
    endcase
  end

  // Outputs decode the current state; rst gates them so no
  // stack, memory or PC side effect happens in a reset cycle.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    pcsrc       = 1'b0;
    PorI        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    IRwrite     = 1'b0;
    MtoS        = 1'b0;
    ldA         = 1'b0;
    ldB         = 1'b0;
    srcA        = 1'b0;
    srcB        = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    tos         = 1'b0;
    ALUop       = ALU_ADD;
    ifetch      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          memread = 1'b1;
          IRwrite = 1'b1;
          srcA    = 1'b1;
          srcB    = 1'b1;
          pcwrite = 1'b1;
          ifetch  = 1'b1;
        end
        S_POPA: begin
          tos = 1'b1;
          ldA = 1'b1;
          pop = 1'b1;
        end
        S_POPB: begin
          tos = 1'b1;
          ldB = 1'b1;
          pop = 1'b1;
        end
        S_EXE:   ALUop = alu_of(opc);
        S_PUSHR: push = 1'b1;
        S_MRD: begin
          PorI    = 1'b1;
          memread = 1'b1;
        end
        S_PUSHM: begin
          MtoS = 1'b1;
          push = 1'b1;
        end
        S_MWR: begin
          PorI     = 1'b1;
          memwrite = 1'b1;
        end
        S_JMP: begin
          pcsrc   = 1'b1;
          pcwrite = 1'b1;
        end
        S_JZ: begin
          tos         = 1'b1;
          pcsrc       = 1'b1;
          pcwritecond = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_mips_ctrl.sv
// Directed bench for stack_mips_ctrl: per-cycle expected strobe
// vectors are queued per instruction and compared as cycles run.
module tb_stack_mips_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opc = 3'b000;
  logic       pcwrite, pcwritecond, pcsrc, PorI, memread;
  logic       memwrite, IRwrite, MtoS, ldA, ldB, srcA, srcB;
  logic       push, pop, tos, ifetch;
  logic [1:0] ALUop;

  stack_mips_ctrl dut (
    .clk(clk), .rst(rst), .opc(opc),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond),
    .pcsrc(pcsrc), .PorI(PorI), .memread(memread),
    .memwrite(memwrite), .IRwrite(IRwrite), .MtoS(MtoS),
    .ldA(ldA), .ldB(ldB), .srcA(srcA), .srcB(srcB),
    .push(push), .pop(pop), .tos(tos),
    .ALUop(ALUop), .ifetch(ifetch)
  );

  always #5 clk = ~clk;

  localparam logic [17:0] M_PCW   = 18'h1 << 17;
  localparam logic [17:0] M_PCWC  = 18'h1 << 16;
  localparam logic [17:0] M_PCSRC = 18'h1 << 15;
  localparam logic [17:0] M_PORI  = 18'h1 << 14;
  localparam logic [17:0] M_MRD   = 18'h1 << 13;
  localparam logic [17:0] M_MWR   = 18'h1 << 12;
  localparam logic [17:0] M_IRW   = 18'h1 << 11;
  localparam logic [17:0] M_MTOS  = 18'h1 << 10;
  localparam logic [17:0] M_LDA   = 18'h1 << 9;
  localparam logic [17:0] M_LDB   = 18'h1 << 8;
  localparam logic [17:0] M_SRCA  = 18'h1 << 7;
  localparam logic [17:0] M_SRCB  = 18'h1 << 6;
  localparam logic [17:0] M_PUSH  = 18'h1 << 5;
  localparam logic [17:0] M_POP   = 18'h1 << 4;
  localparam logic [17:0] M_TOS   = 18'h1 << 3;
  localparam logic [17:0] M_IFET  = 18'h1;

  localparam logic [17:0] E_IF =
    M_PCW | M_MRD | M_IRW | M_SRCA | M_SRCB | M_IFET;
  localparam logic [17:0] E_ID    = 18'h0;
  localparam logic [17:0] E_POPA  = M_TOS | M_LDA | M_POP;
  localparam logic [17:0] E_POPB  = M_TOS | M_LDB | M_POP;
  localparam logic [17:0] E_PUSHR = M_PUSH;
  localparam logic [17:0] E_MRD   = M_PORI | M_MRD;
  localparam logic [17:0] E_PUSHM = M_MTOS | M_PUSH;
  localparam logic [17:0] E_MWR   = M_PORI | M_MWR;
  localparam logic [17:0] E_JMP   = M_PCSRC | M_PCW;
  localparam logic [17:0] E_JZ    = M_TOS | M_PCSRC | M_PCWC;

  logic [17:0] obs;
  assign obs = {pcwrite, pcwritecond, pcsrc, PorI, memread,
                memwrite, IRwrite, MtoS, ldA, ldB, srcA, srcB,
                push, pop, tos, ALUop, ifetch};

  logic [17:0] sb[$];
  int total  = 0;
  int passes = 0;

  function automatic logic [17:0] e_exe(input logic [1:0] a);
    e_exe = {15'h0, a, 1'b0};
  endfunction

  // Queue the expected strobe vector for every cycle of one
  // instruction, IF first; returns its cycle count.
  function automatic int expect_instr(input logic [2:0] op);
    int n;
    sb.push_back(E_IF);
    sb.push_back(E_ID);
    n = 2;
    case (op)
      3'b100: begin
        sb.push_back(E_MRD);
        sb.push_back(E_PUSHM);
        n += 2;
      end
      3'b101: begin
        sb.push_back(E_POPA);
        sb.push_back(E_MWR);
        n += 2;
      end
      3'b110: begin
        sb.push_back(E_JMP);
        n += 1;
      end
      3'b111: begin
        sb.push_back(E_JZ);
        n += 1;
      end
      3'b011: begin
        sb.push_back(E_POPA);
        sb.push_back(e_exe(2'b11));
        sb.push_back(E_PUSHR);
        n += 3;
      end
      default: begin
        sb.push_back(E_POPA);
        sb.push_back(E_POPB);
        sb.push_back(e_exe(op[1:0]));
        sb.push_back(E_PUSHR);
        n += 4;
      end
    endcase
    return n;
  endfunction

  task automatic chk(input string tag);
    logic [17:0] exp;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL %s scoreboard empty obs=%h", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) passes++;
      else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs 1 after the edge, sample 1 later.
  task automatic cyc(input logic r, input logic [2:0] o,
                     input string tag);
    @(posedge clk);
    #1;
    rst = r;
    opc = o;
    #1;
    chk(tag);
  endtask

  task automatic run_instr(input logic [2:0] op,
                           input string tag);
    int n;
    n = expect_instr(op);
    for (int k = 0; k < n; k++) begin
      // IF may see a stale IR; opcode only matters from ID on.
      if (k == 0)
        cyc(1'b0, 3'($urandom_range(0, 7)),
            $sformatf("%s.c%0d", tag, k));
      else
        cyc(1'b0, op, $sformatf("%s.c%0d", tag, k));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      sb.push_back(18'h0);
      cyc(1'b1, 3'($urandom_range(0, 7)),
          $sformatf("reset.c%0d", i));
    end

    run_instr(3'b000, "ADD");
    run_instr(3'b001, "SUB");
    run_instr(3'b010, "AND");
    run_instr(3'b011, "NOT");
    run_instr(3'b100, "PUSH");
    run_instr(3'b101, "POP");
    run_instr(3'b110, "JMP");
    run_instr(3'b111, "JZ");
    run_instr(3'b000, "ADD2");

    // Abort an ADD in POPB: outputs forced low, then a fresh IF.
    sb.push_back(E_IF);
    cyc(1'b0, 3'b000, "abort.IF");
    sb.push_back(E_ID);
    cyc(1'b0, 3'b000, "abort.ID");
    sb.push_back(E_POPA);
    cyc(1'b0, 3'b000, "abort.POPA");
    sb.push_back(18'h0);
    cyc(1'b1, 3'b000, "abort.rstPOPB");
    sb.push_back(18'h0);
    cyc(1'b1, 3'b000, "abort.rst2");
    run_instr(3'b011, "postrst.NOT");
    run_instr(3'b111, "postrst.JZ");

    total++;
    assert (sb.size() == 0) passes++;
    else $error("FAIL sb_drain left=%0d exp=0", sb.size());

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout obs=%h exp=finish", obs);
    $fatal(1, "timeout");
  end

endmodule
